// File: rtl/trigger_conditioner_pkg.sv
// trigger_conditioner_pkg: edge-mode codes, FSM state encoding and event decode shared by the conditioner
package trigger_conditioner_pkg;
  localparam logic [1:0] EDGE_RISE  = 2'b00;
  localparam logic [1:0] EDGE_FALL  = 2'b01;
  localparam logic [1:0] EDGE_BOTH  = 2'b10;
  localparam logic [1:0] EDGE_LEVEL = 2'b11;
  typedef enum logic [1:0] {TC_IDLE, TC_COUNT, TC_HOLDOFF} tc_state_t;
  function automatic logic edge_event(input logic [1:0] mode, input logic filt, input logic filt_d);
    return mode == EDGE_RISE ? filt & ~filt_d :
           mode == EDGE_FALL ? ~filt & filt_d :
           mode == EDGE_BOTH ? filt ^ filt_d : filt;
  endfunction
endpackage

// File: rtl/trigger_conditioner_if.sv
// trigger_conditioner_if: pin, control, config and status bundle of the trigger conditioner
// master drives pin/enable/clear/cfg_* and observes trigger/filt_level/edge_cnt/busy; slave is the conditioner.
interface trigger_conditioner_if #(
  parameter int FILTER_W = 8,
  parameter int COUNT_W  = 8
);
  logic                trig_pin_i;
  logic                enable_i;
  logic                clear_i;
  logic [1:0]          cfg_edge_i;
  logic [FILTER_W-1:0] cfg_filter_i;
  logic [COUNT_W-1:0]  cfg_count_i;
  logic [15:0]         cfg_holdoff_i;
  logic                trigger_o;
  logic                filt_level_o;
  logic [COUNT_W-1:0]  edge_cnt_o;
  logic                busy_o;
  modport master (
    output trig_pin_i, enable_i, clear_i, cfg_edge_i, cfg_filter_i, cfg_count_i, cfg_holdoff_i,
    input  trigger_o, filt_level_o, edge_cnt_o, busy_o
  );
  modport slave (
    input  trig_pin_i, enable_i, clear_i, cfg_edge_i, cfg_filter_i, cfg_count_i, cfg_holdoff_i,
    output trigger_o, filt_level_o, edge_cnt_o, busy_o
  );
endinterface

// File: rtl/trigger_conditioner_sync_filter.sv
// trigger_conditioner_sync_filter: pin synchroniser followed by a stability filter
// i_pin raw async pin, i_filter extra stable cycles required, o_filt filtered level.
module trigger_conditioner_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_pin,
  input  logic [FILTER_W-1:0] i_filter,
  output logic                o_filt
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILTER_W-1:0]    r_fcnt;
  logic                   r_filt;
  logic                   w_s;
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign o_filt = r_filt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_fcnt <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_fcnt <= (w_s == r_filt || r_fcnt == i_filter) ? '0 : r_fcnt + 1'b1;
      if (w_s != r_filt && r_fcnt == i_filter) r_filt <= w_s;
    end
  end
endmodule

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: synchronised, filtered, edge-selected Nth-event trigger strobe with holdoff
// clk/rst plain; bus carries pin, enable, clear, cfg_* in and trigger, filt_level, edge_cnt, busy out.
import trigger_conditioner_pkg::*;
module trigger_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8,
  parameter int COUNT_W     = 8
) (
  input logic clk,
  input logic rst,
  trigger_conditioner_if.slave bus
);
  tc_state_t          r_state, w_state;
  logic [1:0]         r_edge, w_edge;
  logic [COUNT_W-1:0] r_count, w_count, r_cnt, w_cnt, w_max, w_cnt_inc;
  logic [15:0]        r_hold, w_hold, r_hcnt, w_hcnt;
  logic               r_trig, w_trig, r_filt_d, w_filt, w_event, w_fire;
  trigger_conditioner_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_W(FILTER_W)) u_sync_filter (
    .clk      (clk),
    .rst      (rst),
    .i_pin    (bus.trig_pin_i),
    .i_filter (bus.cfg_filter_i),
    .o_filt   (w_filt)
  );
  assign w_event   = edge_event(r_edge, w_filt, r_filt_d);
  assign w_max     = r_count == '0 ? COUNT_W'(1) : r_count;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_fire    = w_cnt_inc == w_max;
  assign bus.trigger_o    = r_trig;
  assign bus.filt_level_o = w_filt;
  assign bus.edge_cnt_o   = r_cnt;
  assign bus.busy_o       = r_state == TC_HOLDOFF;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= TC_IDLE;
      r_edge   <= EDGE_RISE;
      r_count  <= '0;
      r_hold   <= '0;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_trig   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_edge   <= w_edge;
      r_count  <= w_count;
      r_hold   <= w_hold;
      r_cnt    <= w_cnt;
      r_hcnt   <= w_hcnt;
      r_trig   <= w_trig;
      r_filt_d <= w_filt;
    end
  end
  // Priority: disable, arm (config latch), clear, then per-state counting.
  always_comb begin
    w_state = r_state;
    w_edge  = r_edge;
    w_count = r_count;
    w_hold  = r_hold;
    w_cnt   = r_cnt;
    w_hcnt  = r_hcnt;
    w_trig  = 1'b0;
    if (!bus.enable_i) begin
      w_state = TC_IDLE;
      w_cnt   = '0;
    end else if (r_state == TC_IDLE) begin
      w_state = TC_COUNT;
      w_edge  = bus.cfg_edge_i;
      w_count = bus.cfg_count_i;
      w_hold  = bus.cfg_holdoff_i;
      w_cnt   = '0;
    end else if (bus.clear_i) begin
      w_state = TC_COUNT;
      w_cnt   = '0;
    end else if (r_state == TC_COUNT && w_event) begin
      w_cnt   = w_fire ? '0 : w_cnt_inc;
      w_trig  = w_fire;
      w_hcnt  = w_fire ? '0 : r_hcnt;
      w_state = w_fire && r_hold != '0 ? TC_HOLDOFF : TC_COUNT;
    end else if (r_state == TC_HOLDOFF) begin
      w_state = r_hcnt == 16'(r_hold - 1'b1) ? TC_COUNT : TC_HOLDOFF;
      w_hcnt  = r_hcnt + 1'b1;
    end
  end
endmodule
